// File: rtl/showcase_ram_arbiter.sv
// Round-robin arbiter for two valid/ready requesters sharing a small scratch RAM.
// One RAM access per granted request; the response is held until the owner consumes it.
module showcase_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_data,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_data,
  output logic                  busy
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];

  logic grant;
  logic idle;
  logic handshake;
  logic owner_resp_ready;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign idle       = (state_q == StIdle);
  assign req0_ready = idle & req0_valid & ~grant;
  assign req1_ready = idle & req1_valid & grant;
  assign handshake  = req0_ready | req1_ready;

  assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_d        = mem_q;
    case (state_q)
      StIdle: begin
        if (handshake) begin
          owner_d      = grant;
          last_grant_d = grant;
          we_d         = grant ? req1_we   : req0_we;
          addr_d       = grant ? req1_addr : req0_addr;
          wdata_d      = grant ? req1_data : req0_data;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (we_q) begin
          mem_d[addr_q] = wdata_q;
          rdata_d       = wdata_q;
        end else begin
          rdata_d = mem_q[addr_q];
        end
        state_d = StResp;
      end
      StResp: begin
        if (owner_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset also clears the RAM, so an in-flight write is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_q        <= mem_d;
    end
  end

  assign resp0_valid = (state_q == StResp) & ~owner_q;
  assign resp1_valid = (state_q == StResp) & owner_q;
  assign resp0_data  = resp0_valid ? rdata_q : '0;
  assign resp1_data  = resp1_valid ? rdata_q : '0;
  assign busy        = ~idle;

endmodule

// File: doc/showcase_ram_arbiter.md
# showcase_ram_arbiter

Two-requester arbiter and sequencer for the 4-entry x 8-bit scratch RAM used by the showcase datapath. It accepts read/write requests from two independent valid/ready ports and grants them round-robin. It performs one RAM access per granted request and returns a response on a per-requester valid/ready response channel. It owns the RAM storage, so it is the only agent touching the memory.

## Interface
- DATA_WIDTH, 8, RAM word width in bits
- ADDR_WIDTH, 2, RAM address width; depth = 2**ADDR_WIDTH
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester n presents a request
- req0_ready / req1_ready  out  1  request n accepted this cycle when valid&ready
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_WIDTH  RAM address
- req0_data / req1_data  in  DATA_WIDTH  write data (ignored for reads)
- resp0_valid / resp1_valid  out  1  response for requester n pending
- resp0_ready / resp1_ready  in  1  requester n consumes response
- resp0_data / resp1_data  out  DATA_WIDTH  read data, or the written data for writes
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: combinational grant. If only one reqN_valid is high, it wins. If both are high, the requester not equal to last_grant wins. reqN_ready = (state==IDLE) & grant==N; at most one ready is high per cycle. On handshake: latch owner, we, addr, data; set last_grant=owner; go to ACCESS.
- ACCESS (one cycle): write -> mem[addr] <= data, rdata <= data. Read -> rdata <= mem[addr]. Go to RESP.
- RESP: respOwner_valid=1 and respOwner_data=rdata; the other resp_valid=0. Hold until respOwner_ready=1, then go to IDLE. Ready is ignored in other states.
- Address is used as-is; no wrap is needed because ADDR_WIDTH covers the depth exactly.
- RAM read data reflects all previously completed writes, including a write by the other requester in the immediately preceding transaction.
- Non-owner resp_data is 0. resp_data is 0 outside RESP.

## Timing
- Reset (async, immediate on rst_n=0): state=IDLE, last_grant=1 (so requester 0 wins the first tie), all RAM words=0, rdata=0. Outputs: req*_ready follow the IDLE grant rule (0 while no valid); resp*_valid=0, resp*_data=0, busy=0.
- Handshake at cycle T -> ACCESS at T+1 -> resp_valid high from T+2.
- With resp_ready tied high: resp_valid is high for exactly one cycle (T+2), IDLE at T+3, next handshake possible at T+3. Minimum issue interval is 3 cycles.
- Back-to-back requests alternate 0,1,0,1 while both hold valid.
- Request valid dropping while not ready: no effect. Changing req fields after handshake: no effect.
- Reset asserted in ACCESS or RESP: the transaction is aborted, no response is issued, and RAM clears. A write in ACCESS at the reset edge is lost.
- busy=1 in ACCESS and RESP.

## Test plan
- Reset then single write: req0 we=1 addr=2 data=0xA5 -> req0_ready=1 at T, resp0_valid=1 at T+2 with data 0xA5, busy 1 over T+1..T+2. Then req1 read addr=2 -> resp1_data=0xA5.
- Read after reset: req1 read addr=3 -> resp1_data=0x00, resp0_valid stays 0.
- Contention: both valid continuously, req0 writes 0x11@0, req1 writes 0x22@1. Grants go 0,1,0,1, with the first grant to req0. Handshakes every 3 cycles with resp_ready=1. Reads of addrs 0/1 afterwards return 0x11/0x22.
- Response backpressure: req0 read, resp0_ready held 0 for 5 cycles -> resp0_valid and data stable for 5 cycles. req1_ready stays 0 while req1_valid=1. req1 is granted the cycle after resp0_ready=1.
- Reset mid-operation: write 0x5A@1, assert rst_n=0 during RESP -> resp0_valid drops immediately, busy=0. After release, reading addr 1 returns 0x00.
- Cross-requester ordering: req0 writes 0x33@0, and req1's read of addr 0 is granted next -> resp1_data=0x33.
